instr_fetch_unit: RTL and testbench

Initiator side of the 16x8 instruction memory read port. Drives the combinational fetch address, captures returned bytes into a small prefetch buffer tagged with PC, and presents instructions to decode over a valid/ready handshake. Supports control-flow redirect (jump/branch) with buffer flush, and stops fetching past a HLT opcode.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_buf.sv | 62 ++++++
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and the fetch state encoding for the instruction fetch path.
package cpu_pkg;
    localparam int CPU_ADDR_W = 4;
    localparam int CPU_DATA_W = 8;
    localparam int OPC_W      = 4;
    localparam int OPC_MSB    = CPU_DATA_W - 1;
    localparam int OPC_LSB    = CPU_DATA_W - OPC_W;

    localparam logic [OPC_W-1:0] CPU_HLT_OPC = 4'h0;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO holding {instruction, pc} entries; flush empties it in one cycle.
// The head is read combinationally so decode sees a new entry the cycle after it is written.
module fetch_buf #(
    parameter int DEPTH = 2,
    parameter int W     = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [W-1:0]               i_wdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [W-1:0]               o_head
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    // A full buffer may still accept a write when its head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !i_flush && w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: drives imem_addr, buffers returned bytes with their PC,
// handles redirects and stops at HLT. FETCH_PERF_EN adds the retire_count output.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int               ADDR_W    = CPU_ADDR_W,
    parameter int               DATA_W    = CPU_DATA_W,
    parameter int               BUF_DEPTH = 2,
    parameter logic [OPC_W-1:0] HLT_OPC   = CPU_HLT_OPC
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           run,
    output logic [ADDR_W-1:0]              imem_addr,
    input  logic [DATA_W-1:0]              imem_data,
    input  logic                           redir_valid,
    input  logic [ADDR_W-1:0]              redir_addr,
    output logic                           instr_valid,
    input  logic                           instr_ready,
    output logic [DATA_W-1:0]              instr_data,
    output logic [ADDR_W-1:0]              instr_pc,
    output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count,
    output logic                           halted
`ifdef FETCH_PERF_EN
    ,
    output logic [7:0]                     retire_count
`endif
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int ENT_W = DATA_W + ADDR_W;

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_halted;

    logic [ENT_W-1:0]  w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_push_hlt;
    logic              w_head_hlt;

    assign imem_addr   = r_fetch_pc;
    assign instr_valid = !w_empty;
    assign instr_data  = w_head[ENT_W-1:ADDR_W];
    assign instr_pc    = w_head[ADDR_W-1:0];
    assign buf_count   = w_count;
    assign halted      = r_halted;

    assign w_pop      = instr_valid && instr_ready;
    // Redirect wins over fetch: the byte on imem_data belongs to the abandoned path.
    assign w_push     = (r_state == FETCH) && run && !redir_valid && (!w_full || w_pop);
    assign w_push_hlt = (imem_data[DATA_W-1 -: OPC_W] == HLT_OPC);
    assign w_head_hlt = (instr_data[DATA_W-1 -: OPC_W] == HLT_OPC);

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .W     (ENT_W)
    ) u_fetch_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redir_valid),
        .i_wdata ({imem_data, r_fetch_pc}),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= FETCH;
            r_fetch_pc <= '0;
            r_halted   <= 1'b0;
        end else if (redir_valid) begin
            r_state    <= FETCH;
            r_fetch_pc <= redir_addr;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    // fetch_pc parks on the HLT address once it has been captured.
                    if (w_push) begin
                        if (w_push_hlt) begin
                            r_state <= DRAIN;
                        end else begin
                            r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && w_head_hlt) begin
                        r_state  <= HALTED;
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [7:0] r_retire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retire <= 8'd0;
        end else if (w_pop) begin
            r_retire <= r_retire + 8'd1;
        end
    end

    assign retire_count = r_retire;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the expected instruction stream is derived from
// memory contents and each reset/redirect target; a monitor pops and compares on every accept.
module tb_instr_fetch_unit;
    typedef struct packed {
        logic [7:0] data;
        logic [3:0] pc;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       redir_valid = 1'b0;
    logic [3:0] redir_addr = 4'd0;
    logic       instr_ready = 1'b0;
    logic [3:0] imem_addr;
    logic [7:0] imem_data;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic [3:0] instr_pc;
    logic [1:0] buf_count;
    logic       halted;
`ifdef FETCH_PERF_EN
    logic [7:0] retire_count;
`endif

    logic [7:0] mem [16];
    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .redir_valid  (redir_valid),
        .redir_addr   (redir_addr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_data   (instr_data),
        .instr_pc     (instr_pc),
        .buf_count    (buf_count),
        .halted       (halted)
`ifdef FETCH_PERF_EN
        ,
        .retire_count (retire_count)
`endif
    );

    int   checks = 0;
    int   failures = 0;
    ent_t exp_q[$];
    ent_t pend_q[$];
    int   plan_seq = 0;
    int   applied_seq = 0;
    bit   mon_en = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_data;
    logic [3:0] prev_pc;
    bit   halt_expect = 0;
    int   retire_model = 0;
    int   pops_seen = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected decode stream from a start PC: consecutive bytes up to and including the first HLT.
    task automatic plan_stream(input logic [3:0] start);
        logic [3:0] pc;
        ent_t       e;
        pc = start;
        pend_q.delete();
        for (int i = 0; i < 64; i++) begin
            e.data = mem[pc];
            e.pc   = pc;
            pend_q.push_back(e);
            if (mem[pc][7:4] == 4'h0) break;
            pc = pc + 4'd1;
        end
        plan_seq++;
    endtask

    task automatic load_prog();
        logic [7:0] prog [10] = '{8'hA6, 8'hAF, 8'hB4, 8'hBD, 8'hF8, 8'hCB, 8'h9B, 8'hA7, 8'h7B, 8'h00};
        for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? prog[i] : 8'hF1;
    endtask

    task automatic do_reset();
        redir_valid = 1'b0;
        rst_n = 1'b0;
        plan_stream(4'd0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_halted(input int limit, input string name);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        check(name, halted, 1);
    endtask

    task automatic monitor();
        ent_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
`ifdef FETCH_PERF_EN
                check("retire_count", retire_count, retire_model[7:0]);
`endif
                if (halt_expect) begin
                    check("halted_after_hlt", halted, 1);
                    halt_expect = 0;
                end
                if (prev_stall) begin
                    check("stall_data_stable", instr_data, prev_data);
                    check("stall_pc_stable", instr_pc, prev_pc);
                end
                if (rst_n && instr_valid && instr_ready) begin
                    pops_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pop: got %h at pc %0d, required no instruction", instr_data, instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("pop_data", instr_data, e.data);
                        check("pop_pc", instr_pc, e.pc);
                        if (!redir_valid && e.data[7:4] == 4'h0) halt_expect = 1;
                    end
                end
                prev_stall = rst_n && !redir_valid && instr_valid && !instr_ready;
                prev_data  = instr_data;
                prev_pc    = instr_pc;
            end
            if (rst_n && instr_valid && instr_ready) retire_model++;
            if (!rst_n) retire_model = 0;
            if (applied_seq != plan_seq) begin
                exp_q = pend_q;
                applied_seq = plan_seq;
            end
        end
    endtask

    initial begin
        int p0;
        fork
            monitor();
            begin
                #1000000;
                $display("FAIL watchdog: got timeout, required completion");
                $fatal(1, "watchdog");
            end
        join_none

        // Program run with reset values and first-instruction latency.
        load_prog();
        run = 1'b1;
        instr_ready = 1'b1;
        do_reset();
        check("rst_valid", instr_valid, 0);
        check("rst_count", buf_count, 0);
        check("rst_halted", halted, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_data", instr_data, 0);
        check("rst_pc", instr_pc, 0);
        mon_en = 1;
        step();
        check("first_valid", instr_valid, 1);
        check("first_data", instr_data, 8'hA6);
        wait_halted(40, "prog_halted");
        check("prog_stream_done", exp_q.size(), 0);
        check("halt_imem_addr", imem_addr, 9);
`ifdef FETCH_PERF_EN
        check("prog_retire", retire_count, 10);
`endif

        // Decode back-pressure then release.
        instr_ready = 1'b0;
        do_reset();
        repeat (5) step();
        check("stall_count", buf_count, 2);
        check("stall_head_data", instr_data, 8'hA6);
        check("stall_head_pc", instr_pc, 0);
        check("stall_fetch_pc", imem_addr, 2);
        instr_ready = 1'b1;
        repeat (9) step();
        check("release_not_halted", halted, 0);
        step();
        check("release_halted", halted, 1);
        check("release_stream_done", exp_q.size(), 0);

        // Redirect after three pops; BD/F8 must never be issued.
        do_reset();
        step();
        repeat (3) step();
        check("pre_redir_pc", instr_pc, 3);
        instr_ready = 1'b0;
        redir_valid = 1'b1;
        redir_addr  = 4'd6;
        plan_stream(4'd6);
        step();
        redir_valid = 1'b0;
        instr_ready = 1'b1;
        check("redir_flushed", instr_valid, 0);
        step();
        check("redir_valid", instr_valid, 1);
        check("redir_data", instr_data, 8'h9B);
        check("redir_pc", instr_pc, 6);
        wait_halted(30, "redir_halted");
        check("redir_stream_done", exp_q.size(), 0);

        // Redirect out of HALTED.
        redir_valid = 1'b1;
        redir_addr  = 4'd4;
        plan_stream(4'd4);
        step();
        redir_valid = 1'b0;
        check("unhalt", halted, 0);
        check("unhalt_imem_addr", imem_addr, 4);
        step();
        check("unhalt_data", instr_data, 8'hF8);
        check("unhalt_pc", instr_pc, 4);
        wait_halted(30, "unhalt_halted");

        // No HLT: PC wraps with continuous issue.
        for (int i = 0; i < 16; i++) mem[i] = 8'hF1;
        do_reset();
        p0 = pops_seen;
        repeat (40) step();
        check("wrap_pops", pops_seen - p0, 39);
        check("wrap_not_halted", halted, 0);

        // Reset with a full buffer.
        instr_ready = 1'b0;
        repeat (2) step();
        check("prereset_count", buf_count, 2);
        do_reset();
        check("midreset_count", buf_count, 0);
        check("midreset_valid", instr_valid, 0);
`ifdef FETCH_PERF_EN
        check("midreset_retire", retire_count, 0);
`endif

        // Random traffic: run gating, back-pressure, redirects (some with same-cycle pop), resets.
        for (int i = 0; i < 16; i++) mem[i] = {4'($urandom_range(1, 15)), 4'($urandom)};
        mem[$urandom_range(0, 15)] = {4'h0, 4'($urandom)};
        do_reset();
        p0 = pops_seen;
        for (int c = 0; c < 1500; c++) begin
            run         = ($urandom % 4) != 0;
            instr_ready = ($urandom % 3) != 0;
            redir_valid = 1'b0;
            rst_n       = 1'b1;
            if ($urandom % 200 == 0) begin
                rst_n = 1'b0;
                plan_stream(4'd0);
            end else if ($urandom % 25 == 0) begin
                redir_valid = 1'b1;
                redir_addr  = 4'($urandom);
                plan_stream(redir_addr);
            end
            step();
        end
        rst_n = 1'b1;
        redir_valid = 1'b0;
        run = 1'b0;
        instr_ready = 1'b0;
        step();
        check("random_pops_nonzero", (pops_seen - p0) > 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
